lsu_mem_port: RTL and testbench

- Load/store port between the execute stage and the word-aligned, asynchronous-read dual-port data memory.
- Accepts byte-addressed byte/half/word requests and drives the memory's word-addressed read and write ports.
- Extracts and sign/zero-extends load data.
- The memory has no byte enables, so sub-word stores are done as a registered read-modify-write.

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_lane.sv | 41 ++++
 rtl/lsu_mem_port.sv | 154 +++++++++++++++
 tb/tb_lsu_mem_port.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store memory port.
package lsu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_e;

  function automatic logic is_misaligned(
    input size_e      size,
    input logic [1:0] lo
  );
    logic bad;
    bad = 1'b1;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = lo[0];
      SZ_W:    bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: load extract/extend and store lane merge, purely combinational.
module lsu_lane
  import lsu_pkg::*;
(
  input  size_e           size_i,
  input  logic [1:0]      lane_i,
  input  logic            unsigned_i,
  input  logic [XLEN-1:0] word_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] ld_data_o,
  output logic [XLEN-1:0] st_word_o
);

  logic [7:0]  b_sel;
  logic [15:0] h_sel;

  assign b_sel = word_i[{lane_i, 3'b000} +: 8];
  assign h_sel = word_i[{lane_i[1], 4'b0000} +: 16];

  always_comb begin
    ld_data_o = word_i;
    st_word_o = wdata_i;
    case (size_i)
      SZ_B: begin
        ld_data_o = {{24{b_sel[7] & ~unsigned_i}}, b_sel};
        st_word_o = word_i;
        st_word_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_H: begin
        ld_data_o = {{16{h_sel[15] & ~unsigned_i}}, h_sel};
        st_word_o = word_i;
        st_word_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: begin
        ld_data_o = word_i;
        st_word_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: byte/half/word load-store port onto a word-only dual-port RAM.
// LSU_MISALIGN_ERR_EN: flag misaligned/illegal requests instead of aligning them.
module lsu_mem_port #(
  parameter int MEM_AW = 30,
  parameter int XLEN   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [MEM_AW+1:0] req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  output logic              rsp_valid_o,
  output logic [XLEN-1:0]   rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [MEM_AW-1:0] mem_raddr_o,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_waddr_o,
  output logic [XLEN-1:0]   mem_wdata_o
);

  import lsu_pkg::*;

  state_e            state_q, state_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [1:0]        lane_q, lane_d;
  size_e             size_q, size_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;

  size_e             req_size, eff_size, lane_size;
  logic [1:0]        req_lo, eff_lo, lane_lo;
  logic              req_err, accept, sub_st, in_merge;
  logic [MEM_AW-1:0] req_waddr;
  logic [XLEN-1:0]   lane_wdata, ld_data, st_word;

  assign req_size  = size_e'(req_size_i);
  assign req_lo    = req_addr_i[1:0];
  assign req_waddr = req_addr_i[MEM_AW+1:2];

`ifdef LSU_MISALIGN_ERR_EN
  assign req_err  = is_misaligned(req_size, req_lo);
  assign eff_size = req_size;
  assign eff_lo   = req_lo;
`else
  assign req_err = 1'b0;
  always_comb begin
    eff_size = req_size;
    eff_lo   = req_lo;
    case (req_size)
      SZ_B: eff_lo = req_lo;
      SZ_H: eff_lo = {req_lo[1], 1'b0};
      default: begin
        eff_size = SZ_W;
        eff_lo   = 2'b00;
      end
    endcase
  end
`endif

  assign in_merge    = (state_q == MERGE);
  assign req_ready_o = (state_q == IDLE);
  assign accept      = req_valid_i & req_ready_o;
  assign sub_st      = req_we_i & ~req_err &
                       ((eff_size == SZ_B) | (eff_size == SZ_H));

  assign lane_size  = in_merge ? size_q  : eff_size;
  assign lane_lo    = in_merge ? lane_q  : eff_lo;
  assign lane_wdata = in_merge ? wdata_q : req_wdata_i;

  lsu_lane u_lane (
    .size_i     (lane_size),
    .lane_i     (lane_lo),
    .unsigned_i (req_unsigned_i),
    .word_i     (mem_rdata_i),
    .wdata_i    (lane_wdata),
    .ld_data_o  (ld_data),
    .st_word_o  (st_word)
  );

  // Reset gates the write strobe so an abandoned merge never commits.
  assign mem_raddr_o = in_merge ? addr_q  : req_waddr;
  assign mem_waddr_o = in_merge ? addr_q  : req_waddr;
  assign mem_wdata_o = in_merge ? st_word : req_wdata_i;
  assign mem_we_o    = ~rst_i & (in_merge |
                       (accept & req_we_i & ~req_err & ~sub_st));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    lane_d      = lane_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (sub_st) begin
            state_d = MERGE;
            addr_d  = req_waddr;
            lane_d  = eff_lo;
            size_d  = eff_size;
            wdata_d = req_wdata_i;
          end else begin
            rsp_valid_d = 1'b1;
            if (!req_we_i) rsp_rdata_d = ld_data;
          end
        end
      end
      MERGE: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      lane_q      <= '0;
      size_q      <= SZ_B;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: directed table, corner sequences and random ops vs a byte model.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_uns;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [29:0] mem_raddr, mem_waddr;
  logic [31:0] mem_rdata, mem_wdata;
  logic        mem_we;

  lsu_mem_port #(.MEM_AW(30), .XLEN(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_uns),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err),
    .mem_raddr_o    (mem_raddr),
    .mem_rdata_i    (mem_rdata),
    .mem_we_o       (mem_we),
    .mem_waddr_o    (mem_waddr),
    .mem_wdata_o    (mem_wdata)
  );

  always #5 clk = ~clk;

  logic [31:0] tbmem   [64];
  logic [31:0] ref_mem [64];
  logic        bd_we = 1'b0;
  logic [5:0]  bd_idx = '0;
  logic [31:0] bd_val = '0;
  int          we_cnt = 0;

  always @(posedge clk) begin
    if (mem_we && mem_waddr[29:6] == '0) tbmem[mem_waddr[5:0]] <= mem_wdata;
    if (mem_we) we_cnt <= we_cnt + 1;
    if (bd_we) tbmem[bd_idx] <= bd_val;
  end

  assign mem_rdata = (mem_raddr[29:6] == '0) ? tbmem[mem_raddr[5:0]]
                                             : 32'h0BAD0000;

`ifdef LSU_MISALIGN_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic mdl_err(input logic [1:0] sz, input logic [1:0] lo);
    if (!ERR_EN) return 1'b0;
    return (sz == 2'd3) || ((int'(lo) % nbytes(sz)) != 0);
  endfunction

  function automatic logic [1:0] mdl_lo(input logic [1:0] sz, input logic [1:0] lo);
    int l;
    l = int'(lo);
    if (!ERR_EN) l = l - (l % nbytes(sz));
    return l[1:0];
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] word,
      input logic [1:0] sz, input logic uns, input logic [1:0] lo);
    int     n;
    longint m, v;
    n = nbytes(sz);
    m = (64'd1 << (8 * n)) - 1;
    v = (longint'(word) >> (8 * int'(lo))) & m;
    if (!uns && n < 4 && ((v >> (8 * n - 1)) & 1) == 1) v = v - (m + 1);
    return v[31:0];
  endfunction

  function automatic logic [31:0] mdl_store(input logic [31:0] word,
      input logic [1:0] sz, input logic [1:0] lo, input logic [31:0] wd);
    logic [31:0] r;
    r = word;
    for (int i = 0; i < nbytes(sz); i++)
      r[8 * (int'(lo) + i) +: 8] = wd[8 * i +: 8];
    return r;
  endfunction

  task automatic poke(input int idx, input logic [31:0] val);
    bd_we  = 1'b1;
    bd_idx = idx[5:0];
    bd_val = val;
    @(posedge clk);
    @(negedge clk);
    bd_we = 1'b0;
    ref_mem[idx] = val;
  endtask

  // Called and returning at a negedge.
  task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
      input logic [31:0] addr, input logic [31:0] wd,
      output logic [31:0] rd, output logic er, output int lat);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = sz;
    req_uns   = uns;
    req_addr  = addr;
    req_wdata = wd;
    chk("ready_at_issue", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 5) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_we;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, c0;

    rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
    req_uns = 1'b0; req_addr = 32'h8; req_wdata = 32'h12345678;
    repeat (2) @(negedge clk);
    chk("reset_we_gated", {31'd0, mem_we}, 32'd0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    c0 = we_cnt;

    for (int i = 0; i < 64; i++) poke(i, $urandom);
    poke(8, 32'h80FF1234);
    poke(4, 32'h11223344);
    chk("no_stray_writes", we_cnt, c0);

    req_addr = 32'h88;
    #1 chk("raddr_tracks_idle", {2'b0, mem_raddr}, 32'h22);

    tbl[0]  = '{0, 2'd1, 0, 32'h22, 0, 32'hFFFF80FF, 0, 1, 0};
    tbl[1]  = '{0, 2'd1, 1, 32'h22, 0, 32'h000080FF, 0, 1, 0};
    tbl[2]  = '{0, 2'd0, 0, 32'h21, 0, 32'h00000012, 0, 1, 0};
    tbl[3]  = '{0, 2'd0, 0, 32'h23, 0, 32'hFFFFFF80, 0, 1, 0};
    tbl[4]  = '{0, 2'd0, 1, 32'h23, 0, 32'h00000080, 0, 1, 0};
    tbl[5]  = '{0, 2'd2, 0, 32'h20, 0, 32'h80FF1234, 0, 1, 0};
    tbl[6]  = '{0, 2'd2, 0, 32'h22, 0,
                ERR_EN ? 32'h0 : 32'h80FF1234, ERR_EN, 1, 0};
    tbl[7]  = '{0, 2'd1, 0, 32'h21, 0,
                ERR_EN ? 32'h0 : 32'h00001234, ERR_EN, 1, 0};
    tbl[8]  = '{0, 2'd3, 0, 32'h20, 0,
                ERR_EN ? 32'h0 : 32'h80FF1234, ERR_EN, 1, 0};
    tbl[9]  = '{0, 2'd0, 0, 32'h12, 0, 32'h00000022, 0, 1, 0};
    tbl[10] = '{0, 2'd1, 1, 32'h10, 0, 32'h00003344, 0, 1, 0};
    tbl[11] = '{1, 2'd2, 0, 32'h23, 32'h80FF1234, 32'h0, ERR_EN, 1,
                ERR_EN ? 0 : 1};

    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      c0 = we_cnt;
      run_req(tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd,
              rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, tbl[i].exp_err});
      chk($sformatf("vec%0d_lat", i), lat, tbl[i].exp_lat);
      chk($sformatf("vec%0d_wecnt", i), we_cnt - c0, tbl[i].exp_we);
    end

    // sb then immediate lw: read-after-merge
    c0 = we_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_uns = 1'b0;
    req_addr = 32'h11; req_wdata = 32'hFFFFFFAB;
    #1 chk("sb_accept_ready", {31'd0, req_ready}, 32'd1);
    chk("sb_accept_no_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    chk("sb_merge_ready", {31'd0, req_ready}, 32'd0);
    chk("sb_merge_we", {31'd0, mem_we}, 32'd1);
    chk("sb_merge_waddr", {2'b0, mem_waddr}, 32'd4);
    chk("sb_merge_wdata", mem_wdata, 32'h1122AB44);
    chk("sb_merge_no_rsp", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("sb_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("sb_rsp_rdata", rsp_rdata, 32'd0);
    chk("sb_ready_back", {31'd0, req_ready}, 32'd1);
    chk("sb_one_write", we_cnt - c0, 32'd1);
    ref_mem[4] = 32'h1122AB44;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h10;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    chk("raw_lw_valid", {31'd0, rsp_valid}, 32'd1);
    chk("raw_lw_rdata", rsp_rdata, 32'h1122AB44);
    @(posedge clk); @(negedge clk);
    chk("rsp_pulse_drops", {31'd0, rsp_valid}, 32'd0);

    // sw then back-to-back lw
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
    req_addr = 32'h08; req_wdata = 32'hDEADBEEF;
    #1 chk("sw_we", {31'd0, mem_we}, 32'd1);
    chk("sw_waddr", {2'b0, mem_waddr}, 32'd2);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    @(posedge clk); @(negedge clk);
    chk("sw_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("sw_rsp_rdata", rsp_rdata, 32'd0);
    chk("sw_ready", {31'd0, req_ready}, 32'd1);
    ref_mem[2] = 32'hDEADBEEF;
    req_we = 1'b0; req_addr = 32'h08;
    @(posedge clk); @(negedge clk);
    chk("b2b_lw1_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("b2b_ready", {31'd0, req_ready}, 32'd1);
    req_addr = 32'h20;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_lw2_valid", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_lw2_rdata", rsp_rdata, 32'h80FF1234);

    // reset in the middle of a merge
    poke(4, 32'h11223344);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1;
    req_addr = 32'h12; req_wdata = 32'h00005555;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    chk("sh_in_merge", {31'd0, req_ready}, 32'd0);
    c0 = we_cnt;
    rst = 1'b1;
    #1 chk("rst_merge_no_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("rst_merge_no_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("rst_merge_no_write", we_cnt - c0, 32'd0);
    chk("rst_merge_mem", tbmem[4], 32'h11223344);
    rst = 1'b0;
    #1 chk("rst_release_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    chk("rst_release_no_rsp", {31'd0, rsp_valid}, 32'd0);

    // random traffic against the byte-level model
    for (int k = 0; k < 400; k++) begin
      logic        we, uns, e_err;
      logic [1:0]  sz, lo;
      logic [31:0] addr, wd, e_rd;
      int          idx, e_lat;
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      addr = 32'($urandom_range(0, 255));
      wd   = $urandom;
      idx  = int'(addr[7:2]);
      e_err = mdl_err(sz, addr[1:0]);
      lo    = mdl_lo(sz, addr[1:0]);
      e_rd  = (!we && !e_err) ? mdl_load(ref_mem[idx], sz, uns, lo) : 32'd0;
      e_lat = (we && !e_err && nbytes(sz) < 4) ? 2 : 1;
      c0 = we_cnt;
      run_req(we, sz, uns, addr, wd, rd, er, lat);
      chk($sformatf("rnd%0d_rdata", k), rd, e_rd);
      chk($sformatf("rnd%0d_err", k), {31'd0, er}, {31'd0, e_err});
      chk($sformatf("rnd%0d_lat", k), lat, e_lat);
      chk($sformatf("rnd%0d_wecnt", k), we_cnt - c0,
          (we && !e_err) ? 32'd1 : 32'd0);
      if (we && !e_err) ref_mem[idx] = mdl_store(ref_mem[idx], sz, lo, wd);
    end

    for (int i = 0; i < 64; i++)
      chk($sformatf("final_mem%0d", i), tbmem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
